// File: rtl/bat_amateur_pkg.sv
// Shared types and constants for the bat_amateur boot loader.
// Holds the loader state encoding, bus direction codes and default bus widths.
package bat_amateur_pkg;

    localparam int unsigned DEFAULT_ADDRESS_WIDTH = 16;
    localparam int unsigned DEFAULT_DATA_WIDTH    = 16;

    localparam logic RAM_RW_WRITE = 1'b1;
    localparam logic RAM_RW_READ  = 1'b0;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StSetup,
        StStrobe,
        StRelease,
        StRun
    } loader_state_e;

endpackage

// File: rtl/bat_amateur_hold_timer.sv
// Down-counter that keeps the core held for a fixed number of cycles after the last write.
// tc_o pulses in the final enabled cycle so the owner can leave its release state.
module bat_amateur_hold_timer #(
    parameter int unsigned Cycles = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic en_i,
    output logic tc_o
);

    logic [7:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = 8'(Cycles);
        end else if (en_i && count_q != 8'd0) begin
            count_d = count_q - 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = en_i && (count_q == 8'd1);

endmodule

// File: rtl/bat_amateur_loader.sv
// Boot loader: holds the bat_amateur core, streams program words into external RAM,
// then releases the core. The bus is driven only while CPU_HOLD is high.
module bat_amateur_loader
    import bat_amateur_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH  = DEFAULT_ADDRESS_WIDTH,
    parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int unsigned LOAD_BASE      = 0,
    parameter int unsigned RELEASE_CYCLES = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     START,
    input  logic [DATA_WIDTH-1:0]    IN_DATA,
    input  logic                     IN_VALID,
    input  logic                     IN_LAST,
    output logic                     IN_READY,
    output logic [DATA_WIDTH-1:0]    BUS_OUT,
    output logic [ADDRESS_WIDTH-1:0] ADDRESS_OUT,
    output logic                     BUS_OE,
    output logic                     RAM_EN,
    output logic                     RAM_RW,
    output logic                     CPU_HOLD,
    output logic                     BUSY,
    output logic                     DONE,
    output logic                     ERROR,
    output logic [ADDRESS_WIDTH:0]   WORD_COUNT
);

    loader_state_e state_q, state_d;

    logic [ADDRESS_WIDTH-1:0] ptr_q;
    logic [DATA_WIDTH-1:0]    data_q;
    logic                     last_q;
    logic [ADDRESS_WIDTH:0]   count_q;
    logic                     done_q;
    logic                     error_q;

    logic timer_load;
    logic timer_en;
    logic timer_tc;
    logic start_load;
    logic ptr_at_top;

    assign start_load = START && (state_q == StIdle || state_q == StRun);
    assign ptr_at_top = (ptr_q == {ADDRESS_WIDTH{1'b1}});
    assign timer_en   = (state_q == StRelease);

    always_comb begin
        state_d    = state_q;
        timer_load = 1'b0;
        unique case (state_q)
            StIdle, StRun: begin
                if (START) state_d = StWait;
            end
            StWait: begin
                if (IN_VALID) state_d = StSetup;
            end
            StSetup: begin
                state_d = StStrobe;
            end
            StStrobe: begin
                // A write to the top address ends the load even without LAST: the image is truncated.
                if (last_q || ptr_at_top) begin
                    state_d    = StRelease;
                    timer_load = 1'b1;
                end else begin
                    state_d = StWait;
                end
            end
            StRelease: begin
                if (timer_tc) state_d = StRun;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            count_q <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_load) begin
                ptr_q   <= ADDRESS_WIDTH'(LOAD_BASE);
                count_q <= '0;
                done_q  <= 1'b0;
                error_q <= 1'b0;
            end
            if (state_q == StWait && IN_VALID) begin
                data_q <= IN_DATA;
                last_q <= IN_LAST;
            end
            if (state_q == StStrobe) begin
                ptr_q   <= ptr_q + ADDRESS_WIDTH'(1);
                count_q <= count_q + (ADDRESS_WIDTH + 1)'(1);
                if (!last_q && ptr_at_top) error_q <= 1'b1;
            end
            if (state_q == StRelease && timer_tc) begin
                done_q <= 1'b1;
            end
        end
    end

    bat_amateur_hold_timer #(
        .Cycles(RELEASE_CYCLES)
    ) u_hold_timer (
        .clk_i (CLK),
        .rst_ni(RST),
        .load_i(timer_load),
        .en_i  (timer_en),
        .tc_o  (timer_tc)
    );

    // Outputs decode straight from registered state, so reset reaches them without a clock.
    always_comb begin
        IN_READY    = (state_q == StWait);
        BUS_OE      = (state_q == StWait) || (state_q == StSetup) || (state_q == StStrobe);
        RAM_EN      = (state_q == StStrobe);
        RAM_RW      = BUS_OE ? RAM_RW_WRITE : RAM_RW_READ;
        CPU_HOLD    = (state_q != StRun);
        BUSY        = (state_q == StWait) || (state_q == StSetup) ||
                      (state_q == StStrobe) || (state_q == StRelease);
        BUS_OUT     = data_q;
        ADDRESS_OUT = ptr_q;
        DONE        = done_q;
        ERROR       = error_q;
        WORD_COUNT  = count_q;
    end

endmodule

// File: tb/tb_bat_amateur_loader.sv
// Scoreboard bench for bat_amateur_loader: expected RAM writes are queued when words are
// issued and a monitor pops them on every RAM strobe. A second instance covers address wrap.
module tb_bat_amateur_loader;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    // Instance A: default widths, LOAD_BASE 0
    logic        start_a = 1'b0, valid_a = 1'b0, last_a = 1'b0;
    logic [15:0] data_a = '0;
    logic        ready_a, bus_oe_a, ram_en_a, ram_rw_a, hold_a, busy_a, done_a, err_a;
    logic [15:0] bus_out_a, addr_a;
    logic [16:0] wc_a;

    // Instance B: 4-bit addresses starting at 14
    logic        start_b = 1'b0, valid_b = 1'b0, last_b = 1'b0;
    logic [15:0] data_b = '0;
    logic        ready_b, bus_oe_b, ram_en_b, ram_rw_b, hold_b, busy_b, done_b, err_b;
    logic [15:0] bus_out_b;
    logic [3:0]  addr_b;
    logic [4:0]  wc_b;

    bat_amateur_loader u_dut (
        .CLK(CLK), .RST(RST), .START(start_a), .IN_DATA(data_a), .IN_VALID(valid_a),
        .IN_LAST(last_a), .IN_READY(ready_a), .BUS_OUT(bus_out_a), .ADDRESS_OUT(addr_a),
        .BUS_OE(bus_oe_a), .RAM_EN(ram_en_a), .RAM_RW(ram_rw_a), .CPU_HOLD(hold_a),
        .BUSY(busy_a), .DONE(done_a), .ERROR(err_a), .WORD_COUNT(wc_a)
    );

    bat_amateur_loader #(
        .ADDRESS_WIDTH(4), .DATA_WIDTH(16), .LOAD_BASE(14), .RELEASE_CYCLES(4)
    ) u_dut_wrap (
        .CLK(CLK), .RST(RST), .START(start_b), .IN_DATA(data_b), .IN_VALID(valid_b),
        .IN_LAST(last_b), .IN_READY(ready_b), .BUS_OUT(bus_out_b), .ADDRESS_OUT(addr_b),
        .BUS_OE(bus_oe_b), .RAM_EN(ram_en_b), .RAM_RW(ram_rw_b), .CPU_HOLD(hold_b),
        .BUSY(busy_b), .DONE(done_b), .ERROR(err_b), .WORD_COUNT(wc_b)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int strobes_a = 0;
    int last_strobe_a = 0;
    int bus_viol = 0;
    int ready_viol = 0;
    logic prev_ready_a = 1'b0;
    wr_t exp_a[$];
    wr_t exp_b[$];
    logic [15:0] ram_a [int];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge CLK) begin
        cyc++;
        // External RAM model: captures on the strobe edge
        if (RST && ram_en_a && ram_rw_a && bus_oe_a) ram_a[int'(addr_a)] = bus_out_a;
    end

    // Monitor: pops one expected write per strobe and watches bus ownership rules
    always @(negedge CLK) begin
        wr_t w;
        if (RST) begin
            if (bus_oe_a && !hold_a) bus_viol++;
            if (bus_oe_b && !hold_b) bus_viol++;
            if (ram_en_a && bus_oe_a && ram_rw_a !== 1'b1) bus_viol++;
            if (ram_en_b && bus_oe_b && ram_rw_b !== 1'b1) bus_viol++;
            // The cycle before a strobe is setup; ready must be low in both
            if (ram_en_a && (ready_a || prev_ready_a)) ready_viol++;
            if (ram_en_a) begin
                strobes_a++;
                last_strobe_a = cyc;
                if (exp_a.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr_a: unexpected write addr 0x%0h data 0x%0h", addr_a, bus_out_a);
                end else begin
                    w = exp_a.pop_front();
                    chk("wr_a_addr", 64'(addr_a), 64'(w.addr));
                    chk("wr_a_data", 64'(bus_out_a), 64'(w.data));
                end
            end
            if (ram_en_b) begin
                if (exp_b.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr_b: unexpected write addr 0x%0h data 0x%0h", addr_b, bus_out_b);
                end else begin
                    w = exp_b.pop_front();
                    chk("wr_b_addr", 64'(addr_b), 64'(w.addr));
                    chk("wr_b_data", 64'(bus_out_b), 64'(w.data));
                end
            end
            prev_ready_a = ready_a;
        end
    end

    task automatic check_reset(input string p);
        chk({p, "_in_ready"}, 64'(ready_a), 0);
        chk({p, "_bus_oe"}, 64'(bus_oe_a), 0);
        chk({p, "_ram_en"}, 64'(ram_en_a), 0);
        chk({p, "_ram_rw"}, 64'(ram_rw_a), 0);
        chk({p, "_bus_out"}, 64'(bus_out_a), 0);
        chk({p, "_address"}, 64'(addr_a), 0);
        chk({p, "_cpu_hold"}, 64'(hold_a), 1);
        chk({p, "_busy"}, 64'(busy_a), 0);
        chk({p, "_done"}, 64'(done_a), 0);
        chk({p, "_error"}, 64'(err_a), 0);
        chk({p, "_word_count"}, 64'(wc_a), 0);
    endtask

    task automatic pulse_start(input int sel);
        if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
        @(posedge CLK);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Offers one word after a random idle gap and holds it until accepted or the bound expires
    task automatic send(input int sel, input logic [15:0] d, input logic l, input int max_gap,
                        input int bound, output bit acc);
        int gap;
        gap = $urandom_range(max_gap, 0);
        for (int g = 0; g < gap; g++) begin
            @(posedge CLK);
            #1;
        end
        if (sel == 0) begin
            valid_a = 1'b1; data_a = d; last_a = l;
        end else begin
            valid_b = 1'b1; data_b = d; last_b = l;
        end
        acc = 1'b0;
        for (int i = 0; i < bound && !acc; i++) begin
            @(negedge CLK);
            if ((sel == 0) ? ready_a : ready_b) begin
                @(posedge CLK);
                #1;
                acc = 1'b1;
            end
        end
        valid_a = 1'b0;
        valid_b = 1'b0;
        last_a  = 1'b0;
        last_b  = 1'b0;
    endtask

    // Core is held through the strobe cycle plus 4 release cycles, then runs
    task automatic wait_hold(input string p);
        bit fell;
        fell = 1'b0;
        for (int i = 0; i < 80 && !fell; i++) begin
            @(negedge CLK);
            #1;
            if (!hold_a) fell = 1'b1;
        end
        if (!fell) begin
            checks++;
            errors++;
            $display("FAIL %s_hold_fall: got timeout, expected CPU_HOLD low", p);
        end else begin
            chk({p, "_hold_cycles"}, 64'(cyc - last_strobe_a), 64'(5));
        end
    endtask

    task automatic push_a(input int addr, input logic [15:0] d);
        wr_t w;
        w.addr = 32'(addr);
        w.data = 32'(d);
        exp_a.push_back(w);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit acc;
        logic [15:0] d;
        logic [15:0] t2_words [5];
        logic [15:0] t1_words [3];
        int s0;
        int room;
        int exp_acc_b;

        t1_words[0] = 16'h1111;
        t1_words[1] = 16'h2222;
        t1_words[2] = 16'h3333;

        repeat (3) @(posedge CLK);
        #1;
        check_reset("rst0");
        chk("rst0_b_hold", 64'(hold_b), 1);
        RST = 1'b1;
        @(posedge CLK);
        #1;

        // Test 1: three fixed words
        pulse_start(0);
        chk("t1_busy", 64'(busy_a), 1);
        for (int i = 0; i < 3; i++) begin
            push_a(i, t1_words[i]);
            send(0, t1_words[i], i == 2, 0, 40, acc);
            chk("t1_accept", 64'(acc), 1);
        end
        wait_hold("t1");
        chk("t1_word_count", 64'(wc_a), 3);
        chk("t1_done", 64'(done_a), 1);
        chk("t1_error", 64'(err_a), 0);
        chk("t1_busy_idle", 64'(busy_a), 0);
        for (int i = 0; i < 3; i++)
            chk("t1_ram", ram_a.exists(i) ? 64'(ram_a[i]) : 64'hdead_beef, 64'(t1_words[i]));

        // Test 2: random words with random valid gaps
        s0 = strobes_a;
        pulse_start(0);
        for (int i = 0; i < 5; i++) begin
            d = 16'($urandom);
            t2_words[i] = d;
            push_a(i, d);
            send(0, d, i == 4, 3, 40, acc);
            chk("t2_accept", 64'(acc), 1);
        end
        wait_hold("t2");
        chk("t2_strobes", 64'(strobes_a - s0), 5);
        chk("t2_word_count", 64'(wc_a), 5);
        for (int i = 0; i < 5; i++)
            chk("t2_ram", ram_a.exists(i) ? 64'(ram_a[i]) : 64'hdead_beef, 64'(t2_words[i]));

        // Test 3: 4 words without LAST into a 16-word space starting at 14
        room = 16 - 14;
        exp_acc_b = 0;
        pulse_start(1);
        for (int i = 0; i < 4; i++) begin
            wr_t w;
            d = 16'($urandom);
            if (i < room) begin
                w.addr = 32'(14 + i);
                w.data = 32'(d);
                exp_b.push_back(w);
                exp_acc_b++;
            end
            send(1, d, 1'b0, 0, (i < room) ? 40 : 20, acc);
            chk("t3_accept", 64'(acc), 64'(i < room));
        end
        chk("t3_error", 64'(err_b), 1);
        chk("t3_word_count", 64'(wc_b), 64'(exp_acc_b));
        chk("t3_run_hold", 64'(hold_b), 0);
        chk("t3_done", 64'(done_b), 1);

        // Test 4: START ignored in WAIT and RELEASE, honoured in RUN
        pulse_start(0);
        d = 16'($urandom);
        push_a(0, d);
        send(0, d, 1'b0, 0, 40, acc);
        for (int i = 0; i < 20 && !ready_a; i++) @(negedge CLK);
        start_a = 1'b1;
        @(posedge CLK);
        #1;
        start_a = 1'b0;
        chk("t4_wait_ready", 64'(ready_a), 1);
        for (int i = 1; i < 3; i++) begin
            d = 16'($urandom);
            push_a(i, d);
            send(0, d, i == 2, 0, 40, acc);
            chk("t4_accept", 64'(acc), 1);
        end
        @(posedge CLK);
        @(posedge CLK);
        #1;
        pulse_start(0);
        wait_hold("t4");
        chk("t4_word_count", 64'(wc_a), 3);
        chk("t4_done", 64'(done_a), 1);
        chk("t4_hold_before", 64'(hold_a), 0);
        pulse_start(0);
        chk("t4_hold_rise", 64'(hold_a), 1);
        chk("t4_busy_restart", 64'(busy_a), 1);
        chk("t4_done_clear", 64'(done_a), 0);
        chk("t4_wc_clear", 64'(wc_a), 0);
        chk("t4_base", 64'(addr_a), 0);
        for (int i = 0; i < 2; i++) begin
            d = 16'($urandom);
            push_a(i, d);
            send(0, d, i == 1, 1, 40, acc);
        end
        wait_hold("t4b");
        chk("t4b_word_count", 64'(wc_a), 2);

        // Test 5: reset during the strobe of word 2
        pulse_start(0);
        d = 16'($urandom);
        push_a(0, d);
        send(0, d, 1'b0, 0, 40, acc);
        send(0, 16'($urandom), 1'b0, 0, 40, acc);
        @(posedge CLK);
        #2;
        chk("t5_in_strobe", 64'(ram_en_a), 1);
        RST = 1'b0;
        #1;
        check_reset("t5");
        @(posedge CLK);
        #1;
        chk("t5_hold_in_reset", 64'(hold_a), 1);
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("t5_idle_ready", 64'(ready_a), 0);
        chk("t5_idle_hold", 64'(hold_a), 1);
        chk("t5_idle_busy", 64'(busy_a), 0);
        pulse_start(0);
        chk("t5_restart_ready", 64'(ready_a), 1);

        repeat (2) @(posedge CLK);
        #1;
        chk("exp_a_drained", 64'(exp_a.size()), 0);
        chk("exp_b_drained", 64'(exp_b.size()), 0);
        chk("bus_ownership", 64'(bus_viol), 0);
        chk("ready_in_setup_strobe", 64'(ready_viol), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bat_amateur_loader.md
Name: bat_amateur_loader

Overview:
- Synthesizable boot loader on the upstream side of the bat_amateur core. It holds the core in reset and accepts program words on a valid/ready stream. It writes each word into external RAM over the shared address/data bus, then releases the core to execute.
- It is the hardware replacement for the bench stimulus that preloads RAM. It owns the bus only while CPU_HOLD is asserted.

Parameters:
- ADDRESS_WIDTH, 16, width of the RAM address bus.
- DATA_WIDTH, 16, width of RAM words and the data bus.
- LOAD_BASE, 0, first RAM address written by each load.
- RELEASE_CYCLES, 4, cycles CPU_HOLD stays high after the final write (range 1..255).

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  asynchronous active-low reset.
- START  in  1  one-cycle pulse that begins a load.
- IN_DATA  in  DATA_WIDTH  program word.
- IN_VALID  in  1  IN_DATA and IN_LAST are valid.
- IN_LAST  in  1  marks the final word of the image.
- IN_READY  out  1  loader accepts the word this cycle.
- BUS_OUT  out  DATA_WIDTH  write data to RAM.
- ADDRESS_OUT  out  ADDRESS_WIDTH  RAM address.
- BUS_OE  out  1  enables the loader's drivers onto the data and address buses.
- RAM_EN  out  1  RAM strobe.
- RAM_RW  out  1  1 = write (the loader only writes).
- CPU_HOLD  out  1  holds the core in reset/halt; drives the core's RST and external-RAM select.
- BUSY  out  1  a load is in progress.
- DONE  out  1  the last load completed; sticky until the next START.
- ERROR  out  1  the last load overflowed the address space; sticky until the next START.
- WORD_COUNT  out  ADDRESS_WIDTH+1  words written by the current or last load.

Behaviour:
- Reset (RST low, asynchronous), all outputs forced as follows:
  - IN_READY=0, BUS_OE=0, RAM_EN=0, RAM_RW=0.
  - BUS_OUT=0, ADDRESS_OUT=0.
  - CPU_HOLD=1, so the core stays held during and after reset until the first load completes.
  - BUSY=0, DONE=0, ERROR=0, WORD_COUNT=0.
  - State = IDLE.
- States: IDLE, WAIT, SETUP, STROBE, RELEASE, RUN.
- IDLE: CPU_HOLD=1. START moves to WAIT and does the following:
  - address pointer <= LOAD_BASE
  - WORD_COUNT <= 0
  - DONE <= 0, ERROR <= 0
  - BUSY <= 1
- WAIT:
  - IN_READY=1 and BUS_OE=1.
  - On IN_VALID&&IN_READY: latch IN_DATA into BUS_OUT and IN_LAST into the last flag, then go to SETUP.
  - No combinational path from IN_VALID to IN_READY.
- SETUP (1 cycle): ADDRESS_OUT=pointer, BUS_OUT stable, RAM_RW=1, RAM_EN=0. Next state is STROBE.
- STROBE (1 cycle):
  - RAM_EN=1 and RAM_RW=1, so the RAM captures the word on this edge.
  - WORD_COUNT increments and the pointer increments modulo 2^ADDRESS_WIDTH.
  - If the last flag is set: go to RELEASE.
  - Else if the written address was all-ones (pointer wraps to 0): ERROR <= 1, go to RELEASE (the image is truncated).
  - Else: go to WAIT.
- Throughput: one word per 3 cycles maximum (WAIT, SETUP, STROBE); IN_READY is low during SETUP and STROBE.
- RELEASE:
  - BUS_OE=0, RAM_EN=0, RAM_RW=0, CPU_HOLD=1.
  - A down-counter loaded with RELEASE_CYCLES counts down; at terminal count go to RUN.
- RUN: CPU_HOLD=0, BUSY=0, DONE=1, bus drivers off. The core now owns the bus.
- START in RUN moves to WAIT with the same initialisation as IDLE. CPU_HOLD rises in the same cycle the state changes.
- START in WAIT, SETUP, STROBE or RELEASE is ignored.
- Whenever the loader drives the bus, BUS_OE=1 and CPU_HOLD=1 together. BUS_OE never rises while CPU_HOLD=0.
- IN_VALID while IN_READY=0: the word is not consumed and the source must hold it.
- If RST is asserted mid-load, the load is abandoned immediately, the core stays held, and the RAM contents are undefined.

Decomposition:
- Package bat_amateur_pkg holds:
  - the loader state enum,
  - RAM_RW_WRITE=1 and RAM_RW_READ=0,
  - the default ADDRESS_WIDTH and DATA_WIDTH.
- One natural sub-module: bat_amateur_hold_timer, the RELEASE_CYCLES down-counter with load/terminal-count. Everything else stays inline.

Test Plan:
1. Reset, then START, then stream 3 words 0x1111, 0x2222, 0x3333 (LAST on the third).
   - RAM holds them at addresses 0..2; WORD_COUNT=3.
   - CPU_HOLD falls exactly 4 cycles after the third STROBE.
   - DONE=1, ERROR=0.
2. IN_VALID toggled pseudo-randomly with 5 words.
   - Each word is written exactly once, in order.
   - IN_READY is never high in SETUP or STROBE.
   - RAM_EN pulses exactly 5 times.
3. ADDRESS_WIDTH=4, LOAD_BASE=14, 4 words with no LAST.
   - Writes land at 14 and 15, then ERROR=1 and WORD_COUNT=2.
   - The loader goes to RUN; words 3 and 4 are never accepted.
4. START pulsed during WAIT and during RELEASE.
   - The pulse is ignored and the load completes normally.
   - START in RUN re-asserts CPU_HOLD the same cycle and restarts at LOAD_BASE.
5. RST driven low in the STROBE of word 2.
   - All outputs take their reset values asynchronously, before the next clock edge.
   - CPU_HOLD=1 and the state is IDLE.
6. Bus-ownership assertion run across all tests: BUS_OE implies CPU_HOLD, and RAM_EN implies RAM_RW=1 while BUS_OE.
